// File: rtl/arith_pkg.sv
// Shared arithmetic-library package.
// Holds the controller state encoding for the bit-serial arithmetic blocks
// and the legal range of their WIDTH parameter.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Ports:
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow-in
//   d    - difference bit
//   bout - borrow-out (1 when a < b + bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin (mod 2^WIDTH), bout = borrow.
// One bit is resolved per clock through a single full_subtractor cell, LSB first.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset (aborts any operation in flight)
//   start - request, sampled only while ready=1
//   a, b  - minuend / subtrahend, captured on the accepted start
//   bin   - borrow-in, captured on the accepted start
//   ready - high in IDLE only
//   busy  - high in RUN
//   done  - one-cycle pulse when diff/bout take a new result
//   diff  - registered difference, held until the next completion or reset
//   bout  - registered final borrow (1 when a < b + bin, unsigned)
// WIDTH legal range is arith_pkg::WIDTH_MIN..WIDTH_MAX.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             nb;

  full_subtractor u_cell (
    .a   (sa[0]),
    .b   (sb[0]),
    .bin (br),
    .d   (d),
    .bout(nb)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          // Result fills from the top so the first (LSB) bit lands at sr[0]
          // after WIDTH shifts.
          sr <= {d, sr[WIDTH-1:1]};
          br <= nb;
          if (cnt == CW'(WIDTH - 1)) begin
            // Hold cnt on the last bit instead of letting it wrap.
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          diff  <= sr;
          bout  <= br;
          done  <= 1'b1;
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor computing diff = a - b - bin, with a borrow-out. It processes one bit per clock through a single full-subtractor cell, the inverse arithmetic counterpart of the team's ripple full-adder chain. It trades area for latency. Start/done handshake; sits beside the adder blocks in the arithmetic library for area-constrained datapaths.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only while ready=1
a  input  WIDTH  minuend; captured on the accepted start
b  input  WIDTH  subtrahend; captured on the accepted start
bin  input  1  borrow-in; captured on the accepted start
ready  output  1  high in IDLE only
busy  output  1  high in RUN
done  output  1  one-cycle pulse when diff/bout become valid
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow; 1 when a < b + bin (unsigned)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, all internal shift and count registers cleared.
- Reset mid-operation aborts the operation. No done pulse is issued and the result is discarded.
- States:
  - IDLE: when start=1, latch a, b and bin into shift registers sa, sb and borrow flop br; clear cnt; go to RUN.
  - RUN: each edge, computes d = sa[0]^sb[0]^br and nb = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br). It shifts sa and sb right by 1, shifts d into the MSB of the result shift register sr, sets br<=nb and increments cnt. On the edge where cnt==WIDTH-1 it goes to DONE.
  - DONE: diff<=sr (fully shifted), bout<=br, done=1 for this one cycle; next edge goes to IDLE.
- Latency: start sampled at edge E0 gives WIDTH RUN edges, then done=1 during the cycle after edge E0+WIDTH+1 (WIDTH+2 edges from acceptance to the done-high cycle end). For WIDTH=4, done is high in cycle 6 counting the start cycle as 0.
- diff and bout are registered. They hold the last result until the next completion or reset and never change during RUN.
- start is ignored while busy or in DONE; ready=0 in those states. Input changes after acceptance have no effect.
- Back-to-back: start may be asserted in the IDLE cycle immediately following DONE. Minimum issue interval is WIDTH+2 cycles.
- cnt width is $clog2(WIDTH). cnt has no wrap-around; it is cleared on every acceptance.
- Unsigned semantics. Callers derive signed overflow externally from operand MSBs and diff MSB.

Decomposition:
- Shared package arith_pkg: state enum (IDLE, RUN, DONE) and the WIDTH legal-range constants.
- Sub-module full_subtractor (a, b, bin -> d, bout), purely combinational. It is the single bit cell instantiated once in the serial datapath.

Test Plan:
- WIDTH=4, start with a=9, b=3, bin=0 -> done pulse in cycle 6, diff=6, bout=0, ready returns to 1 next cycle.
- a=3, b=9, bin=0 -> diff=0xA, bout=1.
- a=0, b=0, bin=1 -> diff=0xF, bout=1. Then a=0xF, b=0xF, bin=1 -> diff=0xF, bout=1. Then a=0xF, b=0, bin=0 -> diff=0xF, bout=0.
- Accept a=9, b=3; in cycle 2 assert start with a=1, b=1 and change a/b every cycle -> second start ignored, single done, diff=6.
- Accept a=0xC, b=0x5; drive rst_n=0 in cycle 3 -> next cycle ready=1, busy=0, diff=0, bout=0, and no done pulse ever appears.
- Back-to-back: 7-2 then start in the first IDLE cycle after done with 2-7 -> two done pulses 6 cycles apart, diff=5/bout=0 then diff=0xB/bout=1. Plus a WIDTH=8 random sweep of 1000 operands checked against the reference model (a-b-bin).
